// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell is reused WIDTH times, LSB first,
// with the carry held in a flop between bit slices.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             load;
    logic             shift;
    logic             last;
    logic             busy_nxt;
    logic             done_nxt;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Counter returns to 0 on the final slice so it never reaches WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (shift) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_cout;
            sum   <= {fa_sum, sum[WIDTH-1:1]};
            if (last) begin
                cout <= fa_cout;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit full_adder instance to add two WIDTH-bit operands, one bit per clock, LSB first.
- Provides a start/busy/done handshake.
- Latches the operands, sequences the carry through a carry flip-flop, and assembles the result in a shift register.
- Area-cheap alternative to a WIDTH-bit ripple chain of full_adder cells.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while an addition is in progress (RUN state)
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst=1:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flop and bit counter are all cleared.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=0: remain in IDLE.
  - start=1 at edge E0: latch a, b; carry<=cin; cnt<=0; go to RUN; busy=1 from E0.
- RUN, each edge E1..E_WIDTH:
  - full_adder inputs are a_sh[0], b_sh[0] and carry.
  - Its sum bit shifts into sum at the MSB; sum shifts right by one.
  - a_sh and b_sh shift right by one; carry<=full_adder cout; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: cout<=full_adder cout; go to DONE.
- DONE:
  - busy=0 and done=1 for exactly one cycle. This is the cycle after E_WIDTH, i.e. WIDTH edges after the accepting edge.
  - Next edge: go to IDLE, done=0.
- Result holding:
  - sum and cout hold the final result from E_WIDTH until the next accepted start.
  - During RUN, sum shows partial (shifting) contents and must not be sampled.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2**(WIDTH+1). No overflow flag; cout is the only carry indication.
- Handshake:
  - start is ignored in RUN and DONE. It is not queued; the requester must hold or re-assert it in IDLE.
  - Changes to a, b, cin after E0 have no effect on the current operation.
- Back-to-back operation: with start held high continuously, a new operation is accepted on the first IDLE edge. Throughput is one result per WIDTH+2 cycles.
- Reset mid-operation:
  - Immediate abort; all outputs return to their reset values.
  - No done pulse is produced for the aborted operation.
  - The next start after rst deasserts behaves normally.
- Counter bound: cnt never exceeds WIDTH-1 and has no wrap-around in normal operation.

Test Plan (WIDTH=8):
- Single add: a=0x5A, b=0x3C, cin=0, start pulsed 1 cycle.
  - Required: busy high for 8 cycles, then done high for 1 cycle.
  - Required: sum=0x96, cout=0, held afterwards.
- Full carry propagation: a=0xFF, b=0x01, cin=0.
  - Required: sum=0x00, cout=1.
- Max-value add: a=0xFF, b=0xFF, cin=1.
  - Required: sum=0xFF, cout=1.
- Start during busy: start held high for 3 cycles, with a and b changed to 0x00 after E0, original a=0x10, b=0x20.
  - Required: exactly one done pulse, sum=0x30.
  - Required: while start stays high, a second operation begins only after DONE→IDLE.
- Reset mid-operation: rst pulsed asynchronously (between clock edges) after 3 RUN edges.
  - Required: busy=0, sum=0, cout=0 immediately; no done pulse.
  - Then a=0x01, b=0x02 → sum=0x03, cout=0.
- Back-to-back: start tied high with operands fixed at 0x80+0x80.
  - Required: done pulses spaced exactly 10 cycles apart, each with sum=0x00, cout=1.
